// File: rtl/ysyx_24080006_regfile_sb_pkg.sv
// Shared register-file constants, address-width helper and write-port bundle type.
package ysyx_24080006_pkg;

    // Address width for a register file of nreg entries (never narrower than 1 bit).
    function automatic int unsigned rf_addr_width(input int unsigned nreg);
        return (nreg < 2) ? 1 : $clog2(nreg);
    endfunction

    localparam int unsigned XLEN_DEF  = 32;
    localparam int unsigned REG_WIDTH = rf_addr_width(32);
    localparam int unsigned RF_NRD    = 2;
    localparam int unsigned RF_NWR    = 2;

    // One writeback request as produced by writeback arbitration.
    typedef struct packed {
        logic                 en;
        logic                 rel;
        logic [REG_WIDTH-1:0] addr;
        logic [XLEN_DEF-1:0]  data;
    } wr_req_t;

endpackage

// File: rtl/ysyx_24080006_regfile_sb_scoreboard.sv
// Write-pending scoreboard: busy bits, WAW allocate handshake, RAW busy flags, busy count.
module ysyx_24080006_rf_scoreboard
    import ysyx_24080006_pkg::*;
#(
    parameter int unsigned NREG   = 32,
    parameter int unsigned NRD    = RF_NRD,
    parameter int unsigned NWR    = RF_NWR,
    parameter int unsigned BYPASS = 1,
    parameter int unsigned AW     = rf_addr_width(NREG)
) (
    input  logic           clock,
    input  logic           reset,
    input  logic [AW-1:0]  rd_addr [NRD],
    output logic [NRD-1:0] rd_busy,
    input  logic [NWR-1:0] wr_en,
    input  logic [AW-1:0]  wr_addr [NWR],
    input  logic [NWR-1:0] wr_release,
    input  logic           alloc_valid,
    input  logic [AW-1:0]  alloc_addr,
    output logic           alloc_ready,
    output logic [AW:0]    busy_cnt
);

    logic [NREG-1:0] r_busy;
    logic [NREG-1:0] w_busy_nxt;
    logic [NREG-1:0] w_rel_hit;
    logic [AW:0]     r_busy_cnt;
    logic [AW:0]     w_cnt_nxt;

    // Decode which registers are being released by a writeback this cycle.
    always_comb begin
        w_rel_hit = '0;
        for (int unsigned p = 0; p < NWR; p++) begin
            if (wr_en[p] && wr_release[p]) w_rel_hit[wr_addr[p]] = 1'b1;
        end
    end

    // WAW stall: a busy destination is only grantable if it is released this cycle.
    always_comb begin
        alloc_ready = (alloc_addr == '0) || !r_busy[alloc_addr] || w_rel_hit[alloc_addr];
    end

    // Next busy state (allocate beats release) and its popcount.
    always_comb begin
        w_busy_nxt = r_busy & ~w_rel_hit;
        if (alloc_valid && alloc_ready && (alloc_addr != '0)) w_busy_nxt[alloc_addr] = 1'b1;
        w_busy_nxt[0] = 1'b0;
        w_cnt_nxt = '0;
        for (int unsigned r = 0; r < NREG; r++) begin
            w_cnt_nxt = w_cnt_nxt + {{AW{1'b0}}, w_busy_nxt[r]};
        end
    end

    // Busy bits and count update together so the count always matches the bits.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_busy     <= '0;
            r_busy_cnt <= '0;
        end else begin
            r_busy     <= w_busy_nxt;
            r_busy_cnt <= w_cnt_nxt;
        end
    end

    assign busy_cnt = r_busy_cnt;

    if (BYPASS != 0) begin : g_byp
        // Forwarded data is valid, so a register being released reads as not busy.
        always_comb begin
            for (int unsigned i = 0; i < NRD; i++) begin
                rd_busy[i] = r_busy[rd_addr[i]] && !w_rel_hit[rd_addr[i]]
                             && (rd_addr[i] != '0) && !reset;
            end
        end
    end else begin : g_nobyp
        logic [NREG-1:0] w_wr_hit;

        // Decode which registers receive any write this cycle.
        always_comb begin
            w_wr_hit = '0;
            for (int unsigned p = 0; p < NWR; p++) begin
                if (wr_en[p]) w_wr_hit[wr_addr[p]] = 1'b1;
            end
        end

        // Without forwarding, an in-flight write leaves the array stale until next cycle.
        always_comb begin
            for (int unsigned i = 0; i < NRD; i++) begin
                rd_busy[i] = (r_busy[rd_addr[i]] || w_wr_hit[rd_addr[i]])
                             && (rd_addr[i] != '0) && !reset;
            end
        end
    end

endmodule

// File: rtl/ysyx_24080006_regfile_sb.sv
// Multi-port integer register file with same-cycle bypass and integrated write-pending scoreboard.
module ysyx_24080006_regfile_sb
    import ysyx_24080006_pkg::*;
#(
    parameter int unsigned XLEN   = XLEN_DEF,
    parameter int unsigned NREG   = 32,
    parameter int unsigned NRD    = RF_NRD,
    parameter int unsigned NWR    = RF_NWR,
    parameter int unsigned BYPASS = 1,
    localparam int unsigned AW    = rf_addr_width(NREG)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [AW-1:0]   rd_addr [NRD],
    output logic [XLEN-1:0] rd_data [NRD],
    output logic [NRD-1:0]  rd_busy,
    input  logic [NWR-1:0]  wr_en,
    input  logic [AW-1:0]   wr_addr [NWR],
    input  logic [XLEN-1:0] wr_data [NWR],
    input  logic [NWR-1:0]  wr_release,
    input  logic            alloc_valid,
    input  logic [AW-1:0]   alloc_addr,
    output logic            alloc_ready,
    output logic [AW:0]     busy_cnt
);

    logic [XLEN-1:0] r_regs [NREG];

    // Register array; later write ports overwrite earlier ones so the highest index wins.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned r = 0; r < NREG; r++) r_regs[r] <= '0;
        end else begin
            for (int unsigned p = 0; p < NWR; p++) begin
                if (wr_en[p] && (wr_addr[p] != '0)) r_regs[wr_addr[p]] <= wr_data[p];
            end
        end
    end

    // Read muxes with optional forwarding of same-cycle write data (highest port wins).
    always_comb begin
        for (int unsigned i = 0; i < NRD; i++) begin
            rd_data[i] = r_regs[rd_addr[i]];
            if (BYPASS != 0) begin
                for (int unsigned p = 0; p < NWR; p++) begin
                    if (wr_en[p] && (wr_addr[p] == rd_addr[i])) rd_data[i] = wr_data[p];
                end
            end
            if (reset || (rd_addr[i] == '0)) rd_data[i] = '0;
        end
    end

    ysyx_24080006_rf_scoreboard #(
        .NREG   (NREG),
        .NRD    (NRD),
        .NWR    (NWR),
        .BYPASS (BYPASS),
        .AW     (AW)
    ) u_sb (
        .clock       (clock),
        .reset       (reset),
        .rd_addr     (rd_addr),
        .rd_busy     (rd_busy),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_release  (wr_release),
        .alloc_valid (alloc_valid),
        .alloc_addr  (alloc_addr),
        .alloc_ready (alloc_ready),
        .busy_cnt    (busy_cnt)
    );

endmodule

// File: tb/tb_ysyx_24080006_regfile_sb.sv
// Scoreboard bench: bypass and non-bypass register files driven in parallel against a reference model.
module tb_ysyx_24080006_regfile_sb;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  rd_addr [2];
    logic [1:0]  wr_en;
    logic [4:0]  wr_addr [2];
    logic [31:0] wr_data [2];
    logic [1:0]  wr_release;
    logic        alloc_valid;
    logic [4:0]  alloc_addr;

    logic [31:0] rd_data_b [2];
    logic [1:0]  rd_busy_b;
    logic        ready_b;
    logic [5:0]  cnt_b;
    logic [31:0] rd_data_n [2];
    logic [1:0]  rd_busy_n;
    logic        ready_n;
    logic [5:0]  cnt_n;

    always #5 clk = ~clk;

    ysyx_24080006_regfile_sb #(.XLEN(32), .NREG(32), .NRD(2), .NWR(2), .BYPASS(1)) u_dut_byp (
        .clock(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_release(wr_release),
        .alloc_valid(alloc_valid), .alloc_addr(alloc_addr), .alloc_ready(ready_b), .busy_cnt(cnt_b)
    );

    ysyx_24080006_regfile_sb #(.XLEN(32), .NREG(32), .NRD(2), .NWR(2), .BYPASS(0)) u_dut_nobyp (
        .clock(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_n), .rd_busy(rd_busy_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_release(wr_release),
        .alloc_valid(alloc_valid), .alloc_addr(alloc_addr), .alloc_ready(ready_n), .busy_cnt(cnt_n)
    );

    typedef struct packed {
        logic [1:0][31:0] d_byp;
        logic [1:0]       b_byp;
        logic [1:0][31:0] d_nob;
        logic [1:0]       b_nob;
        logic             ready;
        logic [5:0]       cnt;
    } exp_t;

    exp_t exp_q [$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference model: architectural contents and pending-write set.
    logic [31:0] m_mem  [32];
    bit          m_busy [32];

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s[%0d] t=%0t actual=%h required=%h", name, idx, $time, act, req);
    endtask

    // One cycle: drive inputs just after the edge, queue the expected response, advance the model.
    task automatic cyc(input logic rst, input logic [4:0] ra0, input logic [4:0] ra1,
                       input logic [1:0] we, input logic [4:0] wa0, input logic [4:0] wa1,
                       input logic [31:0] wd0, input logic [31:0] wd1, input logic [1:0] rel,
                       input logic av, input logic [4:0] aa);
        exp_t        e;
        logic [4:0]  ra [2];
        logic [4:0]  wa [2];
        logic [31:0] wd [2];
        logic [31:0] d_arr, d_fwd;
        bit          hit_w, hit_r, rdy, alloc_rel;
        int          cnt;
        @(posedge clk);
        #1;
        reset = rst; rd_addr[0] = ra0; rd_addr[1] = ra1;
        wr_en = we; wr_addr[0] = wa0; wr_addr[1] = wa1; wr_data[0] = wd0; wr_data[1] = wd1;
        wr_release = rel; alloc_valid = av; alloc_addr = aa;
        ra[0] = ra0; ra[1] = ra1; wa[0] = wa0; wa[1] = wa1; wd[0] = wd0; wd[1] = wd1;
        if (rst) begin
            for (int r = 0; r < 32; r++) begin
                m_mem[r] = '0;
                m_busy[r] = 1'b0;
            end
        end
        e = '0;
        for (int i = 0; i < 2; i++) begin
            d_arr = m_mem[ra[i]];
            d_fwd = d_arr;
            hit_w = 1'b0;
            hit_r = 1'b0;
            for (int p = 0; p < 2; p++) begin
                if (we[p] && wa[p] == ra[i]) begin
                    d_fwd = wd[p];
                    hit_w = 1'b1;
                    if (rel[p]) hit_r = 1'b1;
                end
            end
            if (!rst && ra[i] != 0) begin
                e.d_byp[i] = d_fwd;
                e.d_nob[i] = d_arr;
                e.b_byp[i] = m_busy[ra[i]] && !hit_r;
                e.b_nob[i] = m_busy[ra[i]] || hit_w;
            end
        end
        alloc_rel = 1'b0;
        for (int p = 0; p < 2; p++) if (we[p] && rel[p] && wa[p] == aa) alloc_rel = 1'b1;
        rdy = (aa == 0) || !m_busy[aa] || alloc_rel;
        cnt = 0;
        for (int r = 0; r < 32; r++) cnt += int'(m_busy[r]);
        e.ready = rdy;
        e.cnt   = 6'(cnt);
        exp_q.push_back(e);
        if (!rst) begin
            for (int p = 0; p < 2; p++) if (we[p] && wa[p] != 0) m_mem[wa[p]] = wd[p];
            for (int p = 0; p < 2; p++) if (we[p] && rel[p]) m_busy[wa[p]] = 1'b0;
            if (av && rdy && aa != 0) m_busy[aa] = 1'b1;
        end
    endtask

    task automatic idle_read(input logic [4:0] ra0, input logic [4:0] ra1);
        cyc(1'b0, ra0, ra1, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 2'b00, 1'b0, 5'd0);
    endtask

    // Monitor: compare every queued expectation against both DUTs mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            for (int i = 0; i < 2; i++) begin
                chk("byp_rd_data", i, rd_data_b[i], mon_e.d_byp[i]);
                chk("byp_rd_busy", i, 32'(rd_busy_b[i]), 32'(mon_e.b_byp[i]));
                chk("nob_rd_data", i, rd_data_n[i], mon_e.d_nob[i]);
                chk("nob_rd_busy", i, 32'(rd_busy_n[i]), 32'(mon_e.b_nob[i]));
            end
            chk("byp_alloc_ready", 0, 32'(ready_b), 32'(mon_e.ready));
            chk("nob_alloc_ready", 0, 32'(ready_n), 32'(mon_e.ready));
            chk("byp_busy_cnt", 0, 32'(cnt_b), 32'(mon_e.cnt));
            chk("nob_busy_cnt", 0, 32'(cnt_n), 32'(mon_e.cnt));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog t=%0t actual=running required=finished", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [4:0] a0, a1;
        reset = 1'b1; rd_addr[0] = '0; rd_addr[1] = '0; wr_en = '0;
        wr_addr[0] = '0; wr_addr[1] = '0; wr_data[0] = '0; wr_data[1] = '0;
        wr_release = '0; alloc_valid = 1'b0; alloc_addr = '0;
        for (int r = 0; r < 32; r++) begin
            m_mem[r] = '0;
            m_busy[r] = 1'b0;
        end

        cyc(1'b1, 5'd3, 5'd0, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 2'b00, 1'b0, 5'd0);
        cyc(1'b1, 5'd3, 5'd0, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 2'b00, 1'b0, 5'd0);

        // Write x3 and read it in the same cycle, then the next cycle.
        cyc(1'b0, 5'd3, 5'd0, 2'b01, 5'd3, 5'd0, 32'hDEADBEEF, 32'd0, 2'b00, 1'b0, 5'd0);
        idle_read(5'd3, 5'd3);

        // Two ports write x4 at once: port 1 wins.
        cyc(1'b0, 5'd4, 5'd3, 2'b11, 5'd4, 5'd4, 32'h11, 32'h22, 2'b00, 1'b0, 5'd0);
        idle_read(5'd4, 5'd0);

        // x0 ignores writes and allocation.
        cyc(1'b0, 5'd0, 5'd0, 2'b11, 5'd0, 5'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 2'b11, 1'b1, 5'd0);
        idle_read(5'd0, 5'd0);

        // Allocate x9, retry (WAW stall), then release with a simultaneous re-allocate.
        cyc(1'b0, 5'd9, 5'd0, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 2'b00, 1'b1, 5'd9);
        cyc(1'b0, 5'd9, 5'd0, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 2'b00, 1'b1, 5'd9);
        cyc(1'b0, 5'd9, 5'd9, 2'b01, 5'd9, 5'd0, 32'h55, 32'd0, 2'b01, 1'b1, 5'd9);
        idle_read(5'd9, 5'd0);
        cyc(1'b0, 5'd9, 5'd0, 2'b10, 5'd0, 5'd9, 32'd0, 32'h56, 2'b10, 1'b0, 5'd0);
        idle_read(5'd9, 5'd0);

        // Fill every non-zero register, then drain two per cycle.
        for (int i = 1; i < 32; i++)
            cyc(1'b0, 5'(i), 5'(i - 1), 2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 2'b00, 1'b1, 5'(i));
        cyc(1'b0, 5'd31, 5'd1, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 2'b00, 1'b1, 5'd12);
        for (int k = 0; k < 16; k++) begin
            a0 = 5'(2 * k + 1);
            a1 = (k < 15) ? 5'(2 * k + 2) : 5'd0;
            cyc(1'b0, a0, a1, (k < 15) ? 2'b11 : 2'b01, a0, a1, $urandom, $urandom,
                (k < 15) ? 2'b11 : 2'b01, 1'b0, 5'd0);
        end
        idle_read(5'd31, 5'd30);

        // Asynchronous reset mid-operation discards x5 data and the x7 allocation.
        cyc(1'b0, 5'd5, 5'd7, 2'b01, 5'd5, 5'd0, 32'h1234, 32'd0, 2'b00, 1'b1, 5'd7);
        idle_read(5'd5, 5'd7);
        cyc(1'b1, 5'd5, 5'd7, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 2'b00, 1'b0, 5'd0);
        cyc(1'b0, 5'd5, 5'd7, 2'b01, 5'd7, 5'd0, 32'h77, 32'd0, 2'b01, 1'b0, 5'd7);
        idle_read(5'd5, 5'd7);

        // Randomized traffic, biased towards a few registers to provoke conflicts.
        for (int n = 0; n < 1500; n++) begin
            logic [4:0] r0, r1, w0, w1, aa;
            logic [1:0] we, rl;
            logic       av, rst;
            bit         narrow;
            narrow = ($urandom_range(0, 1) == 1);
            r0 = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
            r1 = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
            w0 = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
            w1 = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
            aa = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
            we = 2'($urandom);
            rl = 2'($urandom);
            av = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 199) == 0);
            cyc(rst, r0, r1, we, w0, w1, $urandom, $urandom, rl, av, aa);
        end
        idle_read(5'd1, 5'd2);

        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL queue_drain actual=%0d required=0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
